// File: rtl/conv3x3_stage.sv
// Streaming 3x3 Sobel stage: window shift registers, frame position counters, |G| saturated out.
// Optional SOBEL_MAG_EN: output min(|Gx|+|Gy|, max) and ignore kernel_sel.
module conv3x3_stage #(
  parameter int WIDTH  = 640,
  parameter int HEIGHT = 480,
  parameter int PIX_W  = 12
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [PIX_W-1:0] pix_row0,
  input  logic [PIX_W-1:0] pix_row1,
  input  logic [PIX_W-1:0] pix_row2,
  input  logic             kernel_sel,
  output logic             out_valid,
  output logic [PIX_W-1:0] pix_out,
  output logic             frame_done
);

  localparam int CW = (WIDTH  > 1) ? $clog2(WIDTH)  : 1;
  localparam int RW = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
  localparam logic [CW-1:0] COL_LAST  = CW'(WIDTH - 1);
  localparam logic [RW-1:0] ROW_LAST  = RW'(HEIGHT - 1);
  localparam logic [15:0]   PIX_MAX16 = 16'((1 << PIX_W) - 1);

  logic [PIX_W-1:0] w [0:2][0:2];
  logic [CW-1:0]    col_cnt;
  logic [RW-1:0]    row_cnt;
  logic             v1, border1, last1;
`ifndef SOBEL_MAG_EN
  logic             ks1;
`endif

  // Stage 1: window shift, position counters and per-beat flags, all gated by in_valid
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned r = 0; r < 3; r++)
        for (int unsigned c = 0; c < 3; c++)
          w[r][c] <= '0;
      col_cnt <= '0;
      row_cnt <= '0;
      v1      <= 1'b0;
      border1 <= 1'b0;
      last1   <= 1'b0;
`ifndef SOBEL_MAG_EN
      ks1     <= 1'b0;
`endif
    end else begin
      v1 <= in_valid;
      if (in_valid) begin
        for (int unsigned r = 0; r < 3; r++) begin
          w[r][2] <= w[r][1];
          w[r][1] <= w[r][0];
        end
        w[0][0] <= pix_row0;
        w[1][0] <= pix_row1;
        w[2][0] <= pix_row2;
`ifndef SOBEL_MAG_EN
        ks1     <= kernel_sel;
`endif
        border1 <= (col_cnt < CW'(2)) || (row_cnt < RW'(2));
        last1   <= (col_cnt == COL_LAST) && (row_cnt == ROW_LAST);
        if (col_cnt == COL_LAST) begin
          col_cnt <= '0;
          row_cnt <= (row_cnt == ROW_LAST) ? '0 : row_cnt + RW'(1);
        end else begin
          col_cnt <= col_cnt + CW'(1);
        end
      end
    end
  end

  logic signed [15:0] t [0:2][0:2];
  logic signed [15:0] gx, gy;
  logic        [PIX_W-1:0] sat;
`ifdef SOBEL_MAG_EN
  logic [15:0] ax, ay;
  logic [16:0] mag;
`else
  logic signed [15:0] g;
  logic [15:0] ag;
`endif

  // Stage 2 sum and stage 3 abs/saturate are combinational ahead of the output register,
  // which keeps the beat-to-output latency at two edges.
  always_comb begin
    for (int unsigned r = 0; r < 3; r++)
      for (int unsigned c = 0; c < 3; c++)
        t[r][c] = signed'(16'(w[r][c]));
    gx = (t[0][0] - t[0][2]) + ((t[1][0] - t[1][2]) <<< 1) + (t[2][0] - t[2][2]);
    gy = (t[0][0] - t[2][0]) + ((t[0][1] - t[2][1]) <<< 1) + (t[0][2] - t[2][2]);
`ifdef SOBEL_MAG_EN
    ax  = gx[15] ? 16'(-gx) : 16'(gx);
    ay  = gy[15] ? 16'(-gy) : 16'(gy);
    mag = {1'b0, ax} + {1'b0, ay};
    sat = (mag > {1'b0, PIX_MAX16}) ? PIX_MAX16[PIX_W-1:0] : mag[PIX_W-1:0];
`else
    g   = ks1 ? gy : gx;
    ag  = g[15] ? 16'(-g) : 16'(g);
    sat = (ag > PIX_MAX16) ? PIX_MAX16[PIX_W-1:0] : ag[PIX_W-1:0];
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid  <= 1'b0;
      pix_out    <= '0;
      frame_done <= 1'b0;
    end else begin
      out_valid  <= v1;
      frame_done <= v1 & last1;
      if (v1)
        pix_out <= border1 ? '0 : sat;
    end
  end

endmodule

// File: tb/tb_conv3x3_stage.sv
// Scoreboard bench for conv3x3_stage on an 8x4 frame: directed patterns, gaps, saturation, reset.
module tb_conv3x3_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic [11:0] pix_row0, pix_row1, pix_row2;
  logic        kernel_sel;
  logic        out_valid;
  logic [11:0] pix_out;
  logic        frame_done;

  conv3x3_stage #(.WIDTH(8), .HEIGHT(4), .PIX_W(12)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid),
    .pix_row0(pix_row0), .pix_row1(pix_row1), .pix_row2(pix_row2),
    .kernel_sel(kernel_sel), .out_valid(out_valid), .pix_out(pix_out),
    .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [11:0] pix;
    logic        fd;
    int          cyc;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   br = 0, bc = 0;
  bit   stim_done = 1'b0;
  int   checks = 0, errors = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic beat(input logic [11:0] a0, input logic [11:0] a1, input logic [11:0] a2,
                      input logic ks, input logic [11:0] exp_pix);
    @(posedge clk); #1;
    in_valid = 1'b1; pix_row0 = a0; pix_row1 = a1; pix_row2 = a2; kernel_sel = ks;
    q.push_back('{pix: exp_pix, fd: (br == 3 && bc == 7), cyc: cyc + 2});
    if (bc == 7) begin
      bc = 0;
      br = (br == 3) ? 0 : br + 1;
    end else begin
      bc = bc + 1;
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      in_valid = 1'b0;
    end
  endtask

  initial begin
    logic [11:0] tap;
    rst_n = 1'b0; in_valid = 1'b0; kernel_sel = 1'b0;
    pix_row0 = '0; pix_row1 = '0; pix_row2 = '0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // Flat frame: every output zero, one frame_done
    for (int i = 0; i < 32; i++) beat(12'd500, 12'd500, 12'd500, 1'b0, 12'd0);

    // Vertical edge between cols 3 and 4, Gx
    for (int i = 0; i < 32; i++) begin
      tap = (bc >= 4) ? 12'd100 : 12'd0;
      beat(tap, tap, tap, 1'b0, (br >= 2 && (bc == 4 || bc == 5)) ? 12'd400 : 12'd0);
    end

    // Horizontal edge, kernel_sel toggled per beat: Gy=400 interior, Gx=0
    for (int i = 0; i < 32; i++)
      beat(12'd100, 12'd0, 12'd0, (bc % 2) == 1,
           (br >= 2 && bc >= 2 && (bc % 2) == 1) ? 12'd400 : 12'd0);

    // Single bright column: +16380 at col 4, -16380 at col 6, both saturate
    for (int i = 0; i < 32; i++) begin
      tap = (bc == 4) ? 12'd4095 : 12'd0;
      beat(tap, tap, tap, 1'b0, (br >= 2 && (bc == 4 || bc == 6)) ? 12'd4095 : 12'd0);
    end

    // Gapped vertical edge: 1,0,0,1 valid pattern
    for (int i = 0; i < 32; i++) begin
      tap = (bc >= 4) ? 12'd100 : 12'd0;
      beat(tap, tap, tap, 1'b0, (br >= 2 && (bc == 4 || bc == 5)) ? 12'd400 : 12'd0);
      idle(2);
    end

    // Reset after 13 beats: in-flight results are dropped, counters restart
    for (int i = 0; i < 13; i++) beat(12'd500, 12'd500, 12'd500, 1'b0, 12'd0);
    @(posedge clk); #1;
    in_valid = 1'b0;
    rst_n    = 1'b0;
    while (q.size() != 0 && q[$].cyc >= cyc) void'(q.pop_back());
    br = 0; bc = 0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    for (int i = 0; i < 32; i++) beat(12'd500, 12'd500, 12'd500, 1'b0, 12'd0);
    idle(1);
    stim_done = 1'b1;
  end

  initial begin
    exp_t        e;
    logic [11:0] last_pix = '0;
    int          n = 0;
    while ((!stim_done || q.size() != 0) && n < 5000) begin
      @(negedge clk);
      n++;
      if (!rst_n) last_pix = '0;
      if (out_valid) begin
        checks++;
        if (q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_out: cycle %0d out_valid=1 pix_out=%0d, required no output", cyc, pix_out);
        end else begin
          e = q.pop_front();
          if (pix_out !== e.pix) begin
            errors++;
            $display("FAIL pix_out: cycle %0d got %0d expected %0d", cyc, pix_out, e.pix);
          end
          checks++;
          if (frame_done !== e.fd) begin
            errors++;
            $display("FAIL frame_done: cycle %0d got %0b expected %0b", cyc, frame_done, e.fd);
          end
          checks++;
          if (cyc != e.cyc) begin
            errors++;
            $display("FAIL latency: output at cycle %0d expected at cycle %0d", cyc, e.cyc);
          end
          last_pix = e.pix;
        end
      end else begin
        checks++;
        if (pix_out !== last_pix || frame_done !== 1'b0) begin
          errors++;
          $display("FAIL idle_hold: cycle %0d pix_out=%0d frame_done=%0b expected %0d and 0",
                   cyc, pix_out, frame_done, last_pix);
        end
      end
    end
    checks++;
    if (q.size() != 0 || n >= 5000) begin
      errors++;
      $display("FAIL drain: %0d expected outputs never appeared within %0d cycles", q.size(), n);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
